// File: rtl/reorder_buf_pkg.sv
// Shared types for the reorder buffer: register-file index, entry record, default depth.
package reorder_buf_pkg;

    localparam int RobDepth = 8;
    localparam int RegW     = 5;

    typedef logic [RegW-1:0] RegFile_t;

    typedef struct packed {
        logic     valid;
        logic     done;
        logic     exp;
        RegFile_t rd;
    } RobEntry_t;

endpackage

// File: rtl/reorder_buf_rob_ptr.sv
// Wrap-aware ROB pointer: W index bits plus one wrap bit; active-low clear beats increment.
module rob_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         clr_,
    input  logic         inc_,
    output logic [W:0]   ptr_o
);

    logic [W:0] ptr_q;
    logic [W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (!clr_) begin
            ptr_d = '0;
        end else if (!inc_) begin
            ptr_d = ptr_q + (W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buf.sv
// In-order reorder buffer: allocates IDs at tail, marks completion, retires one entry per cycle at head.
// Optional macro ROB_BYPASS_EN: a clean exe strobe on the head entry retires it in the same cycle.
module reorder_buf
    import reorder_buf_pkg::*;
#(
    parameter  int ROB_DEPTH = RobDepth,
    localparam int ROB       = $clog2(ROB_DEPTH)
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic           flush_,
    input  logic           dec_e_,
    input  logic           dec_invalid,
    input  RegFile_t       dec_rd,
    output logic [ROB-1:0] dec_rob_id,
    output logic           rob_busy,
    output logic           rob_empty,
    input  logic           exe_e_,
    input  logic [ROB-1:0] exe_rob_id,
    input  logic           exe_exp,
    output logic           commit_e_,
    output logic [ROB-1:0] com_rob_id,
    output RegFile_t       com_rd,
    output logic           com_exp
);

    logic [ROB:0]   head_q;
    logic [ROB:0]   tail_q;
    logic [ROB-1:0] head_idx;
    logic [ROB-1:0] tail_idx;
    logic           full;
    logic           alloc;
    logic           exe_hit;
    logic           bypass;
    logic           commit;

    RobEntry_t entries_q [ROB_DEPTH];
    RobEntry_t entries_d [ROB_DEPTH];

    assign head_idx = head_q[ROB-1:0];
    assign tail_idx = tail_q[ROB-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[ROB] != tail_q[ROB]);

    // Decode handshake: dec_e_ low is "valid", !rob_busy is "ready"; an entry is taken only
    // on an edge where both hold and flush_ is high. Decode must hold its request while busy.
    assign alloc   = !dec_e_ && !full && flush_;
    assign exe_hit = !exe_e_ && entries_q[exe_rob_id].valid && flush_;

`ifdef ROB_BYPASS_EN
    assign bypass = !exe_e_ && !exe_exp && flush_ && (exe_rob_id == head_idx)
                    && entries_q[head_idx].valid;
`else
    assign bypass = 1'b0;
`endif

    assign commit = flush_ && entries_q[head_idx].valid && (entries_q[head_idx].done || bypass);

    always_comb begin
        entries_d = entries_q;
        if (!flush_) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end else begin
            if (exe_hit) begin
                entries_d[exe_rob_id].done = 1'b1;
                entries_d[exe_rob_id].exp  = entries_q[exe_rob_id].exp | exe_exp;
            end
            if (commit) begin
                entries_d[head_idx].valid = 1'b0;
            end
            // tail never aliases a committing head here: alloc needs !full, commit needs !empty
            if (alloc) begin
                entries_d[tail_idx] = '{valid: 1'b1, done: dec_invalid, exp: dec_invalid, rd: dec_rd};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    rob_ptr #(.W(ROB)) u_head (
        .clk    (clk),
        .reset_ (reset_),
        .clr_   (flush_),
        .inc_   (!commit),
        .ptr_o  (head_q)
    );

    rob_ptr #(.W(ROB)) u_tail (
        .clk    (clk),
        .reset_ (reset_),
        .clr_   (flush_),
        .inc_   (!alloc),
        .ptr_o  (tail_q)
    );

    assign dec_rob_id = tail_idx;
    assign rob_busy   = full;
    assign rob_empty  = (head_q == tail_q);
    assign commit_e_  = !commit;
    assign com_rob_id = head_idx;
    assign com_rd     = entries_q[head_idx].rd;
    assign com_exp    = entries_q[head_idx].exp;

endmodule
